// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types, field widths and width helper for the alarm bank
// Contents: chan_state_e (per-channel state), HOUR_W/MIN_W/SEC_W, clog2().
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } chan_state_e;

    // Bits needed to hold 0..value-1; never returns less than 1 so that
    // degenerate parameters still give a legal vector width.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// rtl/alarm_bank_if.sv - channel programming write port
// Signals: wr_en (one-cycle strobe), wr_idx (target channel), wr_hour, wr_min, wr_arm.
// Modports: master drives the write, slave (alarm_bank) receives it.
interface alarm_bank_if;
    import alarm_pkg::*;

    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [HOUR_W-1:0] wr_hour;
    logic [MIN_W-1:0]  wr_min;
    logic              wr_arm;

    modport master (output wr_en, wr_idx, wr_hour, wr_min, wr_arm);
    modport slave  (input  wr_en, wr_idx, wr_hour, wr_min, wr_arm);

endinterface

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: stored time, arm bit, FSM, shared timer, snooze count
// Inputs:  clk, rst, sec_tick, cur_hour/cur_min/cur_sec, dnd, wr_sel (write aimed here),
//          wr_hour/wr_min/wr_arm, snooze, dismiss.
// Outputs: state_o (current channel state), armed_o (stored arm bit).
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic              dnd,
    input  logic              wr_sel,
    input  logic [HOUR_W-1:0] wr_hour,
    input  logic [MIN_W-1:0]  wr_min,
    input  logic              wr_arm,
    input  logic              snooze,
    input  logic              dismiss,
    output chan_state_e       state_o,
    output logic              armed_o
);

    localparam int TMR_W = clog2((RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC);
    localparam int CNT_W = clog2(MAX_SNOOZE + 1);

    localparam logic [TMR_W-1:0] RING_LOAD   = TMR_W'(RING_SEC - 1);
    localparam logic [TMR_W-1:0] SNOOZE_LOAD = TMR_W'(SNOOZE_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_SNOOZE);

    chan_state_e       state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic              armed_q, armed_d;

    logic trigger;

    assign trigger = sec_tick && armed_q && (state_q == ST_IDLE) &&
                     (cur_hour == hour_q) && (cur_min == min_q) && (cur_sec == '0);

    // Priority chain: dnd > write > dismiss > snooze > second tick.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        hour_d  = hour_q;
        min_d   = min_q;
        armed_d = armed_q;

        if (dnd) begin
            state_d = ST_IDLE;
            // A write during do-not-disturb still lands; the state is idle either way.
            if (wr_sel) begin
                hour_d  = wr_hour;
                min_d   = wr_min;
                armed_d = wr_arm;
                cnt_d   = '0;
            end
        end else if (wr_sel) begin
            hour_d  = wr_hour;
            min_d   = wr_min;
            armed_d = wr_arm;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (dismiss && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else if (snooze && (state_q == ST_RINGING)) begin
            // Snooze beats a coincident tick: the timer reloads without decrementing.
            if (cnt_q < CNT_MAX) begin
                state_d = ST_SNOOZED;
                timer_d = SNOOZE_LOAD;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (sec_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d = ST_RINGING;
                        timer_d = RING_LOAD;
                        cnt_d   = '0;
                    end
                end
                ST_RINGING: begin
                    if (timer_q != '0) timer_d = timer_q - 1'b1;
                    else               state_d = ST_IDLE;
                end
                ST_SNOOZED: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else begin
                        state_d = ST_RINGING;
                        timer_d = RING_LOAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            armed_q <= armed_d;
        end
    end

    assign state_o = state_q;
    assign armed_o = armed_q;

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-channel alarm controller feeding the melody player start
// Inputs:  clk, rst, sec_tick, cur_hour/cur_min/cur_sec, dnd, snooze, dismiss, wr (write port).
// Outputs: ring (any channel ringing, gated by dnd), ring_idx (lowest ringing channel),
//          armed/snoozed (per-channel flags), dot (any channel armed).
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_tick,
    input  logic [HOUR_W-1:0]   cur_hour,
    input  logic [MIN_W-1:0]    cur_min,
    input  logic [SEC_W-1:0]    cur_sec,
    input  logic                dnd,
    input  logic                snooze,
    input  logic                dismiss,
    alarm_bank_if.slave         wr,
    output logic                ring,
    output logic [2:0]          ring_idx,
    output logic [N_ALARMS-1:0] armed,
    output logic [N_ALARMS-1:0] snoozed,
    output logic                dot
);

    logic [N_ALARMS-1:0] ringing;

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
        chan_state_e st;
        logic        wr_sel;

        // Indices >= N_ALARMS match no channel and are silently dropped.
        assign wr_sel = wr.wr_en && (wr.wr_idx == 3'(i));

        alarm_channel #(
            .SNOOZE_SEC (SNOOZE_SEC),
            .RING_SEC   (RING_SEC),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sec_tick (sec_tick),
            .cur_hour (cur_hour),
            .cur_min  (cur_min),
            .cur_sec  (cur_sec),
            .dnd      (dnd),
            .wr_sel   (wr_sel),
            .wr_hour  (wr.wr_hour),
            .wr_min   (wr.wr_min),
            .wr_arm   (wr.wr_arm),
            .snooze   (snooze),
            .dismiss  (dismiss),
            .state_o  (st),
            .armed_o  (armed[i])
        );

        assign ringing[i] = (st == ST_RINGING);
        assign snoozed[i] = (st == ST_SNOOZED);
    end

    // Lowest index wins: scan downward so the last assignment is the smallest.
    always_comb begin
        ring_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) ring_idx = 3'(i);
        end
    end

    assign ring = (|ringing) && !dnd;
    assign dot  = |armed;

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - scoreboard bench for alarm_bank against a seconds-remaining model
module tb_alarm_bank;

    localparam int N          = 4;
    localparam int SNOOZE_SEC = 300;
    localparam int RING_SEC   = 60;
    localparam int MAX_SNOOZE = 3;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic       clk = 1'b0;
    logic       rst, sec_tick, dnd, snooze, dismiss;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic       ring;
    logic [2:0] ring_idx;
    logic [N-1:0] armed, snoozed;
    logic       dot;

    alarm_bank_if wr_if ();

    alarm_bank #(
        .N_ALARMS   (N),
        .SNOOZE_SEC (SNOOZE_SEC),
        .RING_SEC   (RING_SEC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sec_tick (sec_tick),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .dnd      (dnd),
        .snooze   (snooze),
        .dismiss  (dismiss),
        .wr       (wr_if),
        .ring     (ring),
        .ring_idx (ring_idx),
        .armed    (armed),
        .snoozed  (snoozed),
        .dot      (dot)
    );

    always #5 clk = ~clk;

    // Reference model: seconds left in the current ring/snooze period.
    int m_st   [N];
    int m_left [N];
    int m_nsnz [N];
    int m_hour [N];
    int m_min  [N];
    bit m_arm  [N];

    typedef struct {
        logic [N-1:0] ringm;
        logic [N-1:0] arm;
        logic [N-1:0] snz;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_step();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = M_IDLE; m_left[i] = 0; m_nsnz[i] = 0;
                m_hour[i] = 0; m_min[i] = 0; m_arm[i] = 0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            bit tgt;
            tgt = wr_if.wr_en && (int'(wr_if.wr_idx) == i);
            if (tgt) begin
                m_hour[i] = int'(wr_if.wr_hour);
                m_min[i]  = int'(wr_if.wr_min);
                m_arm[i]  = wr_if.wr_arm;
                m_nsnz[i] = 0;
            end
            if (dnd || tgt) begin
                m_st[i] = M_IDLE;
            end else if (dismiss && m_st[i] != M_IDLE) begin
                m_st[i] = M_IDLE;
            end else if (snooze && m_st[i] == M_RING) begin
                if (m_nsnz[i] < MAX_SNOOZE) begin
                    m_st[i] = M_SNZ;
                    m_left[i] = SNOOZE_SEC;
                    m_nsnz[i]++;
                end else begin
                    m_st[i] = M_IDLE;
                end
            end else if (sec_tick) begin
                if (m_st[i] == M_IDLE) begin
                    if (m_arm[i] && int'(cur_hour) == m_hour[i] &&
                        int'(cur_min) == m_min[i] && cur_sec == 0) begin
                        m_st[i] = M_RING;
                        m_left[i] = RING_SEC;
                        m_nsnz[i] = 0;
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (m_st[i] == M_RING) begin
                            m_st[i] = M_IDLE;
                        end else begin
                            m_st[i] = M_RING;
                            m_left[i] = RING_SEC;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_step();
        for (int i = 0; i < N; i++) begin
            e.ringm[i] = (m_st[i] == M_RING);
            e.snz[i]   = (m_st[i] == M_SNZ);
            e.arm[i]   = m_arm[i];
        end
        exp_q.push_back(e);
        #1;
        rst = 1'b0; sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        wr_if.wr_en = 1'b0;
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   idx;
            e = exp_q.pop_front();
            idx = 0;
            for (int i = N - 1; i >= 0; i--) if (e.ringm[i]) idx = i;
            check("ring",     int'(ring),     int'((|e.ringm) && !dnd));
            check("ring_idx", int'(ring_idx), idx);
            check("armed",    int'(armed),    int'(e.arm));
            check("snoozed",  int'(snoozed),  int'(e.snz));
            check("dot",      int'(dot),      int'(|e.arm));
        end
    end

    task automatic wr(input int idx, input int h, input int m, input bit arm);
        wr_if.wr_en = 1'b1; wr_if.wr_idx = 3'(idx);
        wr_if.wr_hour = 5'(h); wr_if.wr_min = 6'(m); wr_if.wr_arm = arm;
        cyc();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        set_time(h, m, s);
        sec_tick = 1'b1;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick_at(12, 0, 5);
    endtask

    function automatic int pick_hour();
        int r;
        r = $urandom_range(0, 3);
        return (r == 0) ? 6 : (r == 1) ? 7 : (r == 2) ? 8 : $urandom_range(0, 23);
    endfunction

    function automatic int pick_min();
        int r;
        r = $urandom_range(0, 3);
        return (r == 0) ? 0 : (r == 1) ? 30 : (r == 2) ? 15 : $urandom_range(0, 59);
    endfunction

    initial begin
        rst = 1'b1; sec_tick = 1'b0; dnd = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        wr_if.wr_en = 1'b0; wr_if.wr_idx = '0; wr_if.wr_hour = '0;
        wr_if.wr_min = '0; wr_if.wr_arm = 1'b0;
        set_time(0, 0, 0);
        rst = 1'b1; cyc();
        cyc();

        // Single alarm: wrong second does not fire, exact time does, auto-timeout after 60 s.
        wr(1, 7, 30, 1'b1);
        tick_at(7, 30, 5);
        tick_at(7, 30, 0);
        ticks(RING_SEC);
        tick_at(7, 30, 0);

        // Snooze cycle up to the limit; one snooze coinciding with a tick.
        snooze = 1'b1; cyc();
        ticks(SNOOZE_SEC);
        snooze = 1'b1; sec_tick = 1'b1; cyc();
        ticks(SNOOZE_SEC);
        snooze = 1'b1; cyc();
        ticks(SNOOZE_SEC);
        snooze = 1'b1; cyc();
        ticks(3);

        // Two channels at once, then dismiss.
        wr(0, 6, 0, 1'b1);
        wr(2, 6, 0, 1'b1);
        tick_at(6, 0, 0);
        ticks(2);
        dismiss = 1'b1; cyc();

        // Do-not-disturb blocks triggers and kills a ringing channel.
        dnd = 1'b1; tick_at(6, 0, 0);
        dnd = 1'b0; cyc();
        wr(0, 6, 0, 1'b0);
        wr(2, 6, 0, 1'b0);
        wr(3, 8, 15, 1'b1);
        tick_at(8, 15, 0);
        cyc();
        dnd = 1'b1; cyc();
        dnd = 1'b0; cyc();

        // Write and trigger on the same channel in one cycle; out-of-range write ignored.
        wr_if.wr_en = 1'b1; wr_if.wr_idx = 3'd1; wr_if.wr_hour = 5'd7;
        wr_if.wr_min = 6'd30; wr_if.wr_arm = 1'b0;
        tick_at(7, 30, 0);
        wr(6, 7, 30, 1'b1);

        // Reset in the middle of a snooze.
        wr(1, 7, 30, 1'b1);
        tick_at(7, 30, 0);
        snooze = 1'b1; cyc();
        ticks(5);
        rst = 1'b1; cyc();
        cyc();

        // Randomised traffic.
        for (int k = 0; k < 4000; k++) begin
            set_time(pick_hour(), pick_min(), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 59));
            sec_tick = ($urandom_range(0, 1) == 1);
            snooze   = ($urandom_range(0, 99) < 3);
            dismiss  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 1) dnd = ~dnd;
            rst      = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 4) begin
                wr_if.wr_en   = 1'b1;
                wr_if.wr_idx  = 3'($urandom_range(0, 7));
                wr_if.wr_hour = 5'(pick_hour());
                wr_if.wr_min  = 6'(pick_min());
                wr_if.wr_arm  = ($urandom_range(0, 3) != 0);
            end
            cyc();
        end

        dnd = 1'b0;
        cyc();
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
Parametrised multi-channel alarm controller; successor to the single-alarm block of the clock top level. Holds N_ALARMS programmable hour:minute alarms. Each channel is compared against the running time-of-day and supports ringing, snooze with a snooze limit, auto-timeout, dismiss, and a global do-not-disturb switch. Sits between the current-time counter and the music/sound path. Its ring output drives the melody player's start input.

Parameters:
N_ALARMS, 4, number of alarm channels (1..8)
SNOOZE_SEC, 300, snooze delay in seconds before re-ring
RING_SEC, 60, seconds a channel rings before auto-dismiss
MAX_SNOOZE, 3, snoozes allowed per trigger; a further snooze acts as dismiss

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sec_tick  in  1  one-cycle pulse, once per second, synchronous to clk
cur_hour  in  5  current hour, binary 0..23
cur_min  in  6  current minute, binary 0..59
cur_sec  in  6  current second, binary 0..59
dnd  in  1  do-not-disturb level (front-panel switch)
wr_en  in  1  one-cycle write strobe for channel programming
wr_idx  in  3  channel index to write; values >= N_ALARMS are ignored
wr_hour  in  5  alarm hour to store
wr_min  in  6  alarm minute to store
wr_arm  in  1  channel enable to store
snooze  in  1  one-cycle pulse from a debounced button
dismiss  in  1  one-cycle pulse from a debounced button
ring  out  1  high while any channel rings and dnd=0
ring_idx  out  3  lowest-index ringing channel; 0 when none is ringing
armed  out  N_ALARMS  per-channel enable bits
snoozed  out  N_ALARMS  per-channel SNOOZED-state flags
dot  out  1  alarm indicator: high when any channel is armed

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - every channel IDLE and disarmed
  - alarm times 00:00
  - snooze counters 0
  - ring=0, ring_idx=0, armed=0, snoozed=0, dot=0
- Per-channel FSM states: IDLE, RINGING, SNOOZED. There is one shared timer per channel.
- Trigger condition: sec_tick=1 and armed and state=IDLE and cur_hour=alarm_hour and cur_min=alarm_min and cur_sec=0.
- IDLE -> RINGING on trigger:
  - timer loads RING_SEC-1
  - snooze count resets to 0
- RINGING, on each sec_tick:
  - if timer>0, decrement timer
  - if timer=0, go to IDLE (auto-dismiss)
- RINGING -> SNOOZED on snooze when snooze count < MAX_SNOOZE:
  - timer loads SNOOZE_SEC-1
  - snooze count increments
- RINGING -> IDLE on snooze when snooze count = MAX_SNOOZE.
- SNOOZED, on each sec_tick:
  - if timer>0, decrement timer
  - if timer=0, go to RINGING and reload the timer with RING_SEC-1
- snooze and dismiss act on every channel currently in RINGING. dismiss also returns every SNOOZED channel to IDLE.
- dnd=1:
  - triggers are discarded
  - RINGING and SNOOZED channels are forced to IDLE on the next edge
  - ring is held 0 combinationally
- Write (wr_en=1, wr_idx < N_ALARMS):
  - target channel takes the stored time and arm bit
  - target channel is forced to IDLE with snooze count 0
- Priority when events coincide in one cycle:
  - rst > dnd > write (same channel) > dismiss > snooze > timer/trigger
  - snooze and sec_tick together: snooze wins and the timer loads without decrementing
- Outputs:
  - ring, ring_idx and snoozed decode combinationally from the state registers
  - ring rises on the edge that samples the triggering sec_tick (visible the following cycle)
- Arithmetic and width rules:
  - timer width is clog2(max(RING_SEC, SNOOZE_SEC)) bits
  - snooze count width is clog2(MAX_SNOOZE+1) bits
  - comparisons are unsigned
  - no wrap: the timer never decrements below 0
- An alarm set to the current minute with cur_sec > 0 does not fire until the next day.

Decomposition:
- Shared package alarm_pkg holds:
  - channel state enum (IDLE/RINGING/SNOOZED)
  - time-field widths: HOUR_W=5, MIN_W=6, SEC_W=6
  - the clog2 helper
- Sub-module alarm_channel: one channel's registers, FSM, timer and comparator; instantiated N_ALARMS times by a generate loop.
- Top-level alarm_bank owns:
  - write decode
  - the ring_idx priority encoder
  - the dnd gating and OR-reductions

Test Plan:
- Reset, program ch1=07:30 armed, drive time 07:30:00 with sec_tick -> ring=1, ring_idx=1 one cycle later; ch0 and ch2..3 stay IDLE.
- Ringing ch1 with no buttons -> after 60 sec_ticks ring=0 and ch1 is IDLE. 07:30:00 the next day rings again.
- Ringing ch1: snooze -> snoozed[1]=1, ring=0. After 300 sec_ticks ring=1. Repeat snooze 3 times; the 4th snooze -> IDLE, snoozed=0.
- ch0=06:00 and ch2=06:00 both armed, trigger -> ring_idx=0. dismiss -> both IDLE, ring=0.
- dnd=1 at 06:00:00 -> ring stays 0 and no channel enters RINGING. Raise dnd while ch3 rings -> ch3 is IDLE next cycle.
- Same cycle: wr_en to ch1 (wr_arm=0) plus trigger on ch1 -> ch1 disarmed and IDLE, armed[1]=0. Assert rst mid-SNOOZED -> all outputs 0 next cycle.
